// File: rtl/add_order.sv
// ---------------------------------------------------------------------------
// add_order
// Inserts a new limit order {id, size, limit} into the buy or sell order RAM.
// The selected side is scanned from word 0. A live entry carrying the same
// id rejects the request. The new order goes into the first tombstone seen,
// otherwise into the first never-used (all-zero) word. If neither exists
// within BOOK_SIZE words, the book is reported full.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start                    request, sampled only while idle
//   side                     0 = buy RAM, 1 = sell RAM
//   id, size, limit          new order fields
//   buy_addr / sell_addr     RAM address (registered-address RAM)
//   buy_wdata / sell_wdata   write word {id, size, limit}
//   buy_we / sell_we         write enable, only on the selected side
//   buy_rdata / sell_rdata   RAM read data, valid the cycle after capture
//   busy                     accepted request in progress (through DONE)
//   done                     one-cycle completion pulse
//   success                  order written, held until next accepted start
//   status                   00 ok, 01 duplicate, 10 full, 11 invalid
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start
// VALIDATE | reject size 0 or an all-ones request word
// READ     | present word i on the selected side's address
// WAIT     | RAM captures the address
// EVAL     | classify the returned word (zero / duplicate / tombstone / live)
// WRITE    | single-cycle write of the new order into the chosen slot
// DONE     | done pulse, results valid
// ---------------------------------------------------------------------------
module add_order #(
    parameter int BOOK_SIZE = 10,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              side,
    input  logic [15:0]       id,
    input  logic [15:0]       size,
    input  logic [15:0]       limit,
    output logic [ADDR_W-1:0] buy_addr,
    output logic [ADDR_W-1:0] sell_addr,
    output logic [47:0]       buy_wdata,
    output logic [47:0]       sell_wdata,
    output logic              buy_we,
    output logic              sell_we,
    input  logic [47:0]       buy_rdata,
    input  logic [47:0]       sell_rdata,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [1:0]        status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
        S_READ,
        S_WAIT,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [47:0]   ALL_ONES = '1;
    localparam logic [ADDR_W:0] BOOK_END = (ADDR_W + 1)'(BOOK_SIZE);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DUP     = 2'b01;
    localparam logic [1:0] ST_FULL    = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    state_t            state;
    logic              side_q;
    logic [15:0]       id_q;
    logic [15:0]       size_q;
    logic [15:0]       limit_q;
    // One bit wider than the address so BOOK_SIZE = 2**ADDR_W does not wrap.
    logic [ADDR_W:0]   i_q;
    logic              tomb_found;
    logic [ADDR_W-1:0] tomb_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [47:0]       wdata_q;
    logic              we_q;

    logic [47:0]       rdata_sel;
    logic [47:0]       req_word;
    logic [ADDR_W:0]   i_next;
    logic [ADDR_W-1:0] cur_addr;
    logic              word_zero;
    logic              word_tomb;
    logic              word_dup;
    logic              req_invalid;

    assign rdata_sel   = side_q ? sell_rdata : buy_rdata;
    assign req_word    = {id_q, size_q, limit_q};
    assign i_next      = i_q + 1'b1;
    assign cur_addr    = i_q[ADDR_W-1:0];
    assign word_zero   = (rdata_sel == 48'd0);
    assign word_tomb   = (rdata_sel == ALL_ONES);
    assign word_dup    = !word_zero && !word_tomb && (rdata_sel[47:32] == id_q);
    assign req_invalid = (size_q == 16'd0) || (req_word == ALL_ONES);

    // The unselected side sees address/data 0 and never a write enable.
    assign buy_addr   = side_q ? '0 : addr_q;
    assign sell_addr  = side_q ? addr_q : '0;
    assign buy_wdata  = side_q ? '0 : wdata_q;
    assign sell_wdata = side_q ? wdata_q : '0;
    assign buy_we     = we_q & ~side_q;
    assign sell_we    = we_q & side_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            side_q     <= 1'b0;
            id_q       <= '0;
            size_q     <= '0;
            limit_q    <= '0;
            i_q        <= '0;
            tomb_found <= 1'b0;
            tomb_addr  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            status     <= ST_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        side_q     <= side;
                        id_q       <= id;
                        size_q     <= size;
                        limit_q    <= limit;
                        i_q        <= '0;
                        tomb_found <= 1'b0;
                        success    <= 1'b0;
                        status     <= ST_OK;
                        busy       <= 1'b1;
                        state      <= S_VALIDATE;
                    end
                end

                S_VALIDATE: begin
                    if (req_invalid) begin
                        status <= ST_INVALID;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        addr_q <= cur_addr;
                        state  <= S_READ;
                    end
                end

                S_READ: state <= S_WAIT;

                S_WAIT: state <= S_EVAL;

                S_EVAL: begin
                    if (word_zero) begin
                        // An earlier tombstone takes precedence over the end slot.
                        addr_q  <= tomb_found ? tomb_addr : cur_addr;
                        wdata_q <= req_word;
                        we_q    <= 1'b1;
                        state   <= S_WRITE;
                    end else if (word_dup) begin
                        status <= ST_DUP;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        if (word_tomb && !tomb_found) begin
                            tomb_found <= 1'b1;
                            tomb_addr  <= cur_addr;
                        end
                        i_q <= i_next;
                        if (i_next == BOOK_END) begin
                            // A tombstone in the very last word also counts.
                            if (tomb_found || word_tomb) begin
                                addr_q  <= tomb_found ? tomb_addr : cur_addr;
                                wdata_q <= req_word;
                                we_q    <= 1'b1;
                                state   <= S_WRITE;
                            end else begin
                                status <= ST_FULL;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end
                        end else begin
                            addr_q <= i_next[ADDR_W-1:0];
                            state  <= S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    we_q    <= 1'b0;
                    success <= 1'b1;
                    status  <= ST_OK;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    we_q  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_order.sv
// ---------------------------------------------------------------------------
// tb_add_order
// Bench for add_order: behavioural buy/sell RAMs with a registered read
// address, directed scenarios and randomized books checked against a
// reference model that applies the insertion rules directly to an array copy
// of each book.
// ---------------------------------------------------------------------------
module tb_add_order;

    localparam int BS = 10;
    localparam int AW = 12;
    localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          side;
    logic [15:0]   id;
    logic [15:0]   size;
    logic [15:0]   limit;
    logic [AW-1:0] buy_addr;
    logic [AW-1:0] sell_addr;
    logic [47:0]   buy_wdata;
    logic [47:0]   sell_wdata;
    logic          buy_we;
    logic          sell_we;
    logic [47:0]   buy_rdata;
    logic [47:0]   sell_rdata;
    logic          busy;
    logic          done;
    logic          success;
    logic [1:0]    status;

    add_order #(.BOOK_SIZE(BS), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .side       (side),
        .id         (id),
        .size       (size),
        .limit      (limit),
        .buy_addr   (buy_addr),
        .sell_addr  (sell_addr),
        .buy_wdata  (buy_wdata),
        .sell_wdata (sell_wdata),
        .buy_we     (buy_we),
        .sell_we    (sell_we),
        .buy_rdata  (buy_rdata),
        .sell_rdata (sell_rdata),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .status     (status)
    );

    always #5 clk = ~clk;

    // Behavioural RAMs; the bench preloads them through a separate load port.
    logic [47:0]   buy_mem  [0:15];
    logic [47:0]   sell_mem [0:15];
    logic [AW-1:0] buy_aq;
    logic [AW-1:0] sell_aq;
    logic          ld_en;
    logic          ld_side;
    logic [3:0]    ld_addr;
    logic [47:0]   ld_data;

    always_ff @(posedge clk) begin
        buy_aq  <= buy_addr;
        sell_aq <= sell_addr;
        if (buy_we)  buy_mem[buy_addr[3:0]]   <= buy_wdata;
        if (sell_we) sell_mem[sell_addr[3:0]] <= sell_wdata;
        if (ld_en) begin
            if (ld_side) sell_mem[ld_addr] <= ld_data;
            else         buy_mem[ld_addr]  <= ld_data;
        end
    end

    assign buy_rdata  = buy_mem[buy_aq[3:0]];
    assign sell_rdata = sell_mem[sell_aq[3:0]];

    // Expected book contents, side 0 = buy, side 1 = sell.
    logic [47:0] model_mem [0:1][0:15];

    int total = 0;
    int bad   = 0;

    bit          held_valid = 1'b0;
    bit          held_ok;
    logic [1:0]  held_st;
    int          last_lat;
    int          last_waddr;
    int          last_bw;
    int          last_sw;

    task automatic load_word(input bit s, input int a, input logic [47:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_side = s;
        ld_addr = a[3:0];
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        model_mem[s][a] = d;
    endtask

    task automatic clear_all();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < BS; a++)
                load_word(s[0], a, 48'd0);
    endtask

    // Reference: walk the book until the first zero word or a live duplicate.
    task automatic model_add(input bit s, input logic [15:0] nid, input logic [15:0] nsz,
                             input logic [15:0] nlim, output logic [1:0] est,
                             output bit eok, output int eaddr, output int elat);
        logic [47:0] req;
        logic [47:0] w;
        int          k;
        int          zero_at;
        int          tomb_at;
        bit          dup;
        req     = {nid, nsz, nlim};
        eok     = 1'b0;
        eaddr   = -1;
        est     = 2'b00;
        elat    = 2;
        zero_at = -1;
        tomb_at = -1;
        dup     = 1'b0;
        k       = BS;
        if (nsz == 16'd0 || req == ALL1) begin
            est  = 2'b11;
            elat = 2;
        end else begin
            for (int j = 0; j < BS; j++) begin
                w = model_mem[s][j];
                if (w == 48'd0) begin
                    zero_at = j;
                    k = j + 1;
                    break;
                end
                if (w != ALL1 && w[47:32] == nid) begin
                    dup = 1'b1;
                    k = j + 1;
                    break;
                end
                if (w == ALL1 && tomb_at < 0) tomb_at = j;
            end
            if (dup) begin
                est  = 2'b01;
                elat = 2 + 3 * k;
            end else if (zero_at >= 0 || tomb_at >= 0) begin
                eok   = 1'b1;
                eaddr = (tomb_at >= 0) ? tomb_at : zero_at;
                elat  = 3 + 3 * k;
            end else begin
                est  = 2'b10;
                elat = 2 + 3 * k;
            end
        end
    endtask

    task automatic check_mem(input string tag);
        int mis;
        mis = 0;
        for (int a = 0; a < BS; a++) begin
            if (buy_mem[a]  !== model_mem[0][a]) mis++;
            if (sell_mem[a] !== model_mem[1][a]) mis++;
        end
        total++;
        if (mis != 0) begin
            bad++;
            $display("FAIL %s mem: %0d words differ from expected, required 0", tag, mis);
        end
    endtask

    // One add request; poke pulses start mid-scan with a different id.
    task automatic do_add(input bit s, input logic [15:0] nid, input logic [15:0] nsz,
                          input logic [15:0] nlim, input bit poke, input string tag);
        logic [1:0] est;
        bit         eok;
        int         eaddr;
        int         elat;
        int         lat;
        int         bw;
        int         sw;
        int         waddr;
        bit         seen;
        bit         busy_at_done;
        model_add(s, nid, nsz, nlim, est, eok, eaddr, elat);

        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: busy=%b done=%b, required 0 0", tag, busy, done);
        end
        if (held_valid) begin
            total++;
            if (success !== held_ok || status !== held_st) begin
                bad++;
                $display("FAIL %s held: success=%b status=%b, required %b %b",
                         tag, success, status, held_ok, held_st);
            end
        end
        side  = s;
        id    = nid;
        size  = nsz;
        limit = nlim;
        start = 1'b1;
        @(posedge clk);

        lat = 0;
        bw = 0;
        sw = 0;
        waddr = -1;
        seen = 1'b0;
        busy_at_done = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                side  = ~s;
                id    = ~nid;
                size  = 16'(~nsz);
                limit = ~nlim;
            end
            if (poke && elat > 6 && lat == 3) begin
                start = 1'b1;
                side  = ~s;
                id    = nid ^ 16'h00F0;
            end
            if (lat == 4) start = 1'b0;
            if (buy_we === 1'b1) begin
                bw++;
                waddr = int'(buy_addr);
            end
            if (sell_we === 1'b1) begin
                sw++;
                waddr = int'(sell_addr);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                busy_at_done = busy;
            end
        end

        if (eok) model_mem[s][eaddr] = {nid, nsz, nlim};

        total++;
        if (!seen || lat != elat) begin
            bad++;
            $display("FAIL %s latency: done after %0d cycles (seen=%b), required %0d",
                     tag, lat, seen, elat);
        end
        total++;
        if (success !== eok || status !== est || busy_at_done !== 1'b1) begin
            bad++;
            $display("FAIL %s result: success=%b status=%b busy=%b, required %b %b 1",
                     tag, success, status, busy_at_done, eok, est);
        end
        total++;
        if ((s ? sw : bw) != (eok ? 1 : 0) || (s ? bw : sw) != 0 || (eok && waddr != eaddr)) begin
            bad++;
            $display("FAIL %s write: buy_we=%0d sell_we=%0d addr=%0d, required %0d on side %0d at %0d",
                     tag, bw, sw, waddr, eok ? 1 : 0, s, eaddr);
        end
        check_mem(tag);

        held_valid = 1'b1;
        held_ok    = eok;
        held_st    = est;
        last_lat   = lat;
        last_waddr = waddr;
        last_bw    = bw;
        last_sw    = sw;
    endtask

    task automatic check_outputs_zero(input string tag);
        total++;
        if ({busy, done, success, status, buy_we, sell_we, buy_addr, sell_addr,
             buy_wdata, sell_wdata} !== '0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b success=%b status=%b we=%b%b addr=%h/%h wdata=%h/%h, required all 0",
                     tag, busy, done, success, status, buy_we, sell_we, buy_addr, sell_addr,
                     buy_wdata, sell_wdata);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        start   = 1'b0;
        side    = 1'b0;
        id      = '0;
        size    = '0;
        limit   = '0;
        ld_en   = 1'b0;
        ld_side = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        #1;
        check_outputs_zero("reset_async");
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_held");
        rst = 1'b1;
        clear_all();
    endtask

    task automatic test_empty_add();
        do_add(1'b0, 16'd5, 16'd100, 16'd200, 1'b0, "empty_add");
        total++;
        if (buy_mem[0] !== 48'h0005_0064_00C8 || last_lat != 6 || success !== 1'b1 || status !== 2'b00) begin
            bad++;
            $display("FAIL empty_add_word: word0=%h lat=%0d success=%b status=%b, required 000500640 0c8 6 1 00",
                     buy_mem[0], last_lat, success, status);
        end
    endtask

    task automatic test_tomb_reuse();
        clear_all();
        load_word(1'b1, 0, 48'h0001_0010_0020);
        load_word(1'b1, 1, ALL1);
        load_word(1'b1, 2, 48'h0003_0030_0040);
        do_add(1'b1, 16'd7, 16'd70, 16'd77, 1'b1, "tomb_reuse");
        total++;
        if (last_waddr != 1 || last_sw != 1 || last_bw != 0 || last_lat != 15 ||
            sell_mem[1] !== 48'h0007_0046_004D) begin
            bad++;
            $display("FAIL tomb_reuse_slot: addr=%0d sell_we=%0d buy_we=%0d lat=%0d word1=%h, required 1 1 0 15 00070046004d",
                     last_waddr, last_sw, last_bw, last_lat, sell_mem[1]);
        end
    endtask

    task automatic test_dup_after_tomb();
        clear_all();
        load_word(1'b0, 0, ALL1);
        load_word(1'b0, 1, 48'h0009_0001_0002);
        do_add(1'b0, 16'd9, 16'd5, 16'd6, 1'b0, "dup_after_tomb");
        total++;
        if (status !== 2'b01 || success !== 1'b0 || last_bw != 0 || buy_mem[0] !== ALL1) begin
            bad++;
            $display("FAIL dup_after_tomb_const: status=%b success=%b we=%0d word0=%h, required 01 0 0 ffffffffffff",
                     status, success, last_bw, buy_mem[0]);
        end
    endtask

    task automatic test_full();
        clear_all();
        for (int a = 0; a < BS; a++)
            load_word(1'b0, a, {16'(10 + a), 16'd1, 16'(a)});
        do_add(1'b0, 16'd4, 16'd8, 16'd9, 1'b1, "full");
        total++;
        if (status !== 2'b10 || last_bw != 0 || last_lat != 32) begin
            bad++;
            $display("FAIL full_const: status=%b we=%0d lat=%0d, required 10 0 32",
                     status, last_bw, last_lat);
        end
        load_word(1'b0, 6, ALL1);
        do_add(1'b0, 16'd4, 16'd8, 16'd9, 1'b0, "full_tomb");
        total++;
        if (last_waddr != 6 || status !== 2'b00 || last_lat != 33 || buy_mem[6] !== 48'h0004_0008_0009) begin
            bad++;
            $display("FAIL full_tomb_const: addr=%0d status=%b lat=%0d word6=%h, required 6 00 33 000400080009",
                     last_waddr, status, last_lat, buy_mem[6]);
        end
    endtask

    task automatic test_invalid();
        do_add(1'b0, 16'd3, 16'd0, 16'd1, 1'b0, "invalid_size0");
        total++;
        if (status !== 2'b11 || last_lat != 2 || last_bw != 0) begin
            bad++;
            $display("FAIL invalid_size0_const: status=%b lat=%0d we=%0d, required 11 2 0",
                     status, last_lat, last_bw);
        end
        do_add(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, "invalid_ones");
        total++;
        if (status !== 2'b11 || last_lat != 2 || last_sw != 0) begin
            bad++;
            $display("FAIL invalid_ones_const: status=%b lat=%0d we=%0d, required 11 2 0",
                     status, last_lat, last_sw);
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        load_word(1'b0, 0, 48'h0001_0001_0001);
        load_word(1'b0, 1, 48'h0002_0002_0002);
        load_word(1'b0, 2, 48'h0003_0003_0003);
        @(negedge clk);
        side  = 1'b0;
        id    = 16'd9;
        size  = 16'd1;
        limit = 16'd1;
        start = 1'b1;
        @(posedge clk);
        // Word 2: VALIDATE=1, words 0/1 take 2..7, READ of word 2 at 8, WAIT at 9.
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        @(negedge clk);
        check_outputs_zero("reset_mid_held");
        rst = 1'b1;
        held_valid = 1'b0;
        check_mem("reset_mid");
        do_add(1'b0, 16'd9, 16'd1, 16'd1, 1'b0, "after_reset");
        total++;
        if (last_waddr != 3 || buy_mem[3] !== 48'h0009_0001_0001) begin
            bad++;
            $display("FAIL after_reset_slot: addr=%0d word3=%h, required 3 000900010001",
                     last_waddr, buy_mem[3]);
        end
    endtask

    task automatic test_random();
        int          n;
        int          r;
        logic [47:0] w;
        bit          s;
        logic [15:0] rid;
        logic [15:0] rsz;
        logic [15:0] rlim;
        for (int it = 0; it < 30; it++) begin
            for (int sd = 0; sd < 2; sd++) begin
                n = (it % 5 == 0) ? BS : int'($urandom_range(0, BS));
                for (int j = 0; j < BS; j++) begin
                    if (j < n) begin
                        r = int'($urandom_range(0, 3));
                        if (r == 0) w = ALL1;
                        else w = {16'($urandom_range(1, 6)), 16'($urandom_range(1, 1000)),
                                  16'($urandom_range(0, 65535))};
                    end else begin
                        w = 48'd0;
                    end
                    load_word(sd[0], j, w);
                end
            end
            for (int op = 0; op < 2; op++) begin
                s = 1'($urandom_range(0, 1));
                r = int'($urandom_range(0, 9));
                rid  = 16'($urandom_range(1, 8));
                rsz  = 16'($urandom_range(1, 1000));
                rlim = 16'($urandom_range(0, 65535));
                if (r == 0) rsz = 16'd0;
                if (r == 1) begin
                    rid  = 16'hFFFF;
                    rsz  = 16'hFFFF;
                    rlim = 16'hFFFF;
                end
                do_add(s, rid, rsz, rlim, op[0], "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_add();
        test_tomb_reuse();
        test_dup_after_tomb();
        test_full();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
